// File: rtl/alu_seq_exec.sv
// ---------------------------------------------------------------------------
// alu_seq_exec
//   Multi-cycle execute unit fed by the ALU opcode decoder. An opcode and two
//   operands arrive over a valid/ready handshake; the result and a zero flag
//   leave over a second valid/ready handshake toward writeback/branch logic.
//   Shifts iterate one bit per cycle through a single-position shifter so no
//   barrel shifter is built; every other opcode completes in one cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort: return to IDLE and drop any op in flight
//   in_valid   opcode/operands valid
//   in_ready   unit can accept (high only in IDLE)
//   opcode     4-bit ALU opcode
//   a, b       operands; shift amount is b[SHW-1:0]
//   out_valid  result valid (HOLD state)
//   out_ready  consumer accepts result
//   result     registered result
//   zero       result == 0, derived combinationally from the result register
// ---------------------------------------------------------------------------
module alu_seq_exec #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      opcode,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SLT = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_HOLD
    } state_t;

    typedef enum logic [1:0] {
        SH_LL,  // logical left
        SH_RL,  // logical right, zero fill
        SH_RA   // arithmetic right, sign fill
    } shtype_t;

    state_t          state, state_nxt;
    shtype_t         shtype, shtype_in;
    logic [XLEN-1:0] shreg;
    logic [XLEN-1:0] shreg_step;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  count;
    logic [SHW-1:0]  shamt;
    logic            is_shift;
    logic            accept;
    logic            slt_bit;

    assign shamt   = b[SHW-1:0];
    assign slt_bit = ($signed(a) < $signed(b));
    assign accept  = in_valid & (state == S_IDLE) & ~flush;

    // -----------------------------------------------------------------------
    // One-cycle ALU. Shift opcodes yield `a` here, which is exactly the
    // result for a zero shift amount; non-zero shifts go through SHIFT.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in a combinational block is given a
        // default first so no path leaves it unassigned (no latch).
        alu_res   = '0;
        is_shift  = 1'b0;
        shtype_in = SH_LL;
        case (opcode)
            OP_ADD: alu_res = a + b;
            OP_SUB: alu_res = a - b;
            OP_SLT: alu_res = {{(XLEN-1){1'b0}}, slt_bit};
            OP_XOR: alu_res = a ^ b;
            OP_OR:  alu_res = a | b;
            OP_AND: alu_res = a & b;
            OP_SLL: begin
                alu_res   = a;
                is_shift  = 1'b1;
                shtype_in = SH_LL;
            end
            OP_SRL: begin
                alu_res   = a;
                is_shift  = 1'b1;
                shtype_in = SH_RL;
            end
            OP_SRA: begin
                alu_res   = a;
                is_shift  = 1'b1;
                shtype_in = SH_RA;
            end
            default: alu_res = '0;  // unused codes: zero, no error
        endcase
    end

    // Single-position shifter used once per SHIFT cycle.
    always_comb begin
        shreg_step = shreg;
        case (shtype)
            SH_LL:   shreg_step = {shreg[XLEN-2:0], 1'b0};
            SH_RL:   shreg_step = {1'b0, shreg[XLEN-1:1]};
            SH_RA:   shreg_step = {shreg[XLEN-1], shreg[XLEN-1:1]};
            default: shreg_step = shreg;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            state <= state_nxt;
        end
    end

    // FSM: next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_nxt = (is_shift && (shamt != '0)) ? S_SHIFT : S_HOLD;
                end
            end
            S_SHIFT: begin
                if (count == SHW'(1)) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                // No accept in the same cycle: IDLE is entered first.
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // flush overrides everything; a HOLD+out_ready+flush is a drop.
        if (flush) begin
            state_nxt = S_IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers. flush leaves them untouched so the last result
    // stays visible; reset clears them so no partial result survives.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these are plain flops, not a memory array, so all of them
            // (operand register and count included) are reset.
            result <= '0;
            shreg  <= '0;
            count  <= '0;
            shtype <= SH_LL;
        end else if (!flush) begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_shift && (shamt != '0)) begin
                            shreg  <= a;
                            count  <= shamt;
                            shtype <= shtype_in;
                        end else begin
                            result <= alu_res;
                        end
                    end
                end
                S_SHIFT: begin
                    shreg <= shreg_step;
                    count <= count - SHW'(1);
                    // count reaches 1 last, so it never wraps below zero.
                    if (count == SHW'(1)) begin
                        result <= shreg_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign zero = (result == '0);

endmodule
